demux16b8_seq: RTL and testbench
================================

Name: demux16b8_seq

Overview:
- Registered 1-to-8 demultiplexer for 16-bit words. It is the distribution-side counterpart of the 16-bit 8:1 select mux.
- Each input word is steered into one of eight held output registers A..H.
- The target comes from an explicit select S or from an internal auto-increment pointer.
- Per-slot valid flags, a frame-full indication and overwrite detection let a downstream 8:1 mux or consumer know when all eight lanes hold fresh data.

Parameters:
- WIDTH, 16, data word width of I and A..H.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- I  input  WIDTH  data word to distribute.
- S  input  3  explicit target slot (0=A .. 7=H); used when AUTO=0.
- WE  input  1  write strobe; one word accepted per cycle WE=1.
- AUTO  input  1  1: target = internal pointer PTR; 0: target = S.
- CLR  input  1  synchronous clear of valid flags, pointer, error.
- A,B,C,D,E,F,G,H  output  WIDTH each  held slot registers 0..7.
- V  output  8  per-slot valid flags, bit k = slot k.
- PTR  output  3  current auto-increment pointer.
- FULL  output  1  all eight slots valid (V==8'hFF).
- DONE  output  1  one-cycle pulse on the cycle FULL first becomes 1.
- ERR  output  1  sticky overwrite error.

Behaviour:
- Reset (RST_N=0, asynchronous): A..H=0, V=0, PTR=0, FULL=0, DONE=0, ERR=0, FSM=EMPTY.
- Target T = AUTO ? PTR : S, sampled at the clock edge.
- Latency: a word written at edge n is visible on slot T, and V[T]=1, after edge n. There is no combinational path from I to A..H.
- WE=1, CLR=0: slot[T]<=I; V[T]<=1.
  - If AUTO=1, PTR<=PTR+1 with wrap 7->0.
  - If AUTO=0, PTR is unchanged.
- Overwrite: WE=1 with V[T] already 1 -> data still overwritten and ERR<=1. ERR stays 1 until CLR or reset.
- CLR=1 has priority over WE:
  - V<=0, PTR<=0, ERR<=0, FSM<=EMPTY, DONE<=0.
  - Data registers A..H keep their values.
  - A WE in the same cycle is ignored: no data update and no PTR advance.
- WE=0, CLR=0: all state held; DONE<=0.
- FSM states:
  - EMPTY (V==0).
  - FILLING (0<V<FF).
  - FULLST (V==FF).
- FSM transitions:
  - EMPTY->FILLING on the first accepted write.
  - FILLING->FULLST when the write sets the last 0 bit of V. DONE<=1 for exactly one cycle at this transition.
  - FULLST stays in FULLST on further writes (overwrites, ERR set); DONE does not re-pulse.
  - Any state ->EMPTY on CLR.
- FULL is a registered output equal to (FSM==FULLST).
- Mixing AUTO and explicit writes is legal. PTR advances only on AUTO writes, so slots may be overwritten (ERR) or skipped (FULL never reached).
- S and AUTO are ignored when WE=0.
- RST_N deasserted mid-frame: immediate clear as in reset; the first write after release targets PTR=0 (AUTO) or S.

Decomposition:
- Package demux16b8_pkg holds:
  - N_SLOTS=8, SEL_W=3.
  - FSM state typedef {EMPTY, FILLING, FULLST} in 2-bit encoding.
  - Constant ALL_VALID=8'hFF.
- One sub-module is natural: demux16b8_slot.
  - Contains a WIDTH-bit data register plus a valid bit.
  - Inputs: load, clear, data.
  - Instantiated 8 times.
- The top module holds the target decode, PTR, FSM, DONE and ERR.

Test Plan:
- Reset then AUTO=1, WE=1 for 8 cycles with I=16'h0000..16'h0007 -> A..H=0..7, V bit k set after edge k, PTR wraps to 0, FULL=1 and DONE=1 for exactly one cycle after the 8th write, ERR=0.
- AUTO=0, WE=1, S=5, I=16'hBEEF -> F=16'hBEEF next cycle, V=8'h20, PTR=0. Repeat S=5, I=16'h1234 -> F=16'h1234, ERR=1 and sticky.
- Fill all 8 slots, then CLR=1 with WE=1, I=16'hFFFF, AUTO=1 -> V=0, PTR=0, ERR=0, FULL=0, A..H unchanged (no 16'hFFFF anywhere).
- AUTO=1, 3 writes (16'hA0..A2), then RST_N pulsed low mid-cycle -> A..H, V, PTR, FULL immediately 0 without a clock edge. The next AUTO write 16'h55 lands in A.
- WE=0 with S and I toggling for 10 cycles after a partial fill -> no change to A..H, V, PTR. DONE stays 0.
- Explicit fill in order S=7..0, then one more write to S=0 -> DONE pulses once at the 8th write only, FULL stays 1, ERR=1 after the 9th.

Source files
------------

// File: rtl/demux16b8_pkg.sv
// Shared constants and FSM state type for the registered 1-to-8 word demultiplexer.
package demux16b8_pkg;
  localparam int N_SLOTS = 8;
  localparam int SEL_W   = 3;
  localparam logic [N_SLOTS-1:0] ALL_VALID = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULLST  = 2'd2
  } state_t;
endpackage

// File: rtl/demux16b8_slot.sv
// One held output lane: data register plus its valid flag.
module demux16b8_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // clear drops only the valid flag; held data survives a frame clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= data;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/demux16b8_seq.sv
// Registered 1-to-8 demux: steers each written word into one of eight held lanes
// chosen by S or an auto-increment pointer, tracking frame fill and overwrites.
// Handshake: a word is accepted on every rising CLK edge where WE=1 and CLR=0; no backpressure.
module demux16b8_seq
  import demux16b8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   I,
  input  logic [SEL_W-1:0]   S,
  input  logic               WE,
  input  logic               AUTO,
  input  logic               CLR,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   E,
  output logic [WIDTH-1:0]   F,
  output logic [WIDTH-1:0]   G,
  output logic [WIDTH-1:0]   H,
  output logic [N_SLOTS-1:0] V,
  output logic [SEL_W-1:0]   PTR,
  output logic               FULL,
  output logic               DONE,
  output logic               ERR,
  output state_t             dbg_state
);

  logic [SEL_W-1:0]   tgt;
  logic [N_SLOTS-1:0] hit;
  logic [N_SLOTS-1:0] v_next;
  logic [WIDTH-1:0]   q [N_SLOTS];
  state_t             state, state_nx;
  logic [SEL_W-1:0]   ptr_q, ptr_nx;
  logic               err_q, err_nx;
  logic               done_q, done_nx;

  assign tgt    = AUTO ? ptr_q : S;
  assign v_next = V | hit;

  // CLR wins over WE, so a write in a clear cycle selects no lane
  always_comb begin
    hit = '0;
    if (WE && !CLR) hit[tgt] = 1'b1;
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    demux16b8_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (CLK),
      .rst_n (RST_N),
      .load  (hit[k]),
      .clear (CLR),
      .data  (I),
      .q     (q[k]),
      .valid (V[k])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= EMPTY;
      ptr_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr_q  <= ptr_nx;
      err_q  <= err_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr_q;
    err_nx   = err_q;
    done_nx  = 1'b0;
    if (CLR) begin
      state_nx = EMPTY;
      ptr_nx   = '0;
      err_nx   = 1'b0;
    end else if (WE) begin
      if (V[tgt]) err_nx = 1'b1;
      if (AUTO) ptr_nx = ptr_q + 1'b1;
      state_nx = (v_next == ALL_VALID) ? FULLST : FILLING;
      // DONE marks only the entry into FULLST, never later overwrites
      done_nx  = (state != FULLST) && (v_next == ALL_VALID);
    end
  end

  assign A = q[0];
  assign B = q[1];
  assign C = q[2];
  assign D = q[3];
  assign E = q[4];
  assign F = q[5];
  assign G = q[6];
  assign H = q[7];

  assign PTR       = ptr_q;
  assign ERR       = err_q;
  assign DONE      = done_q;
  assign FULL      = (state == FULLST);
  assign dbg_state = state;

endmodule

// File: tb/tb_demux16b8_seq.sv
// Scenario bench for demux16b8_seq with a behavioural model and expected-word queue.
module tb_demux16b8_seq;
  logic        CLK, RST_N;
  logic [15:0] I;
  logic [2:0]  S;
  logic        WE, AUTO, CLR;
  logic [15:0] A, B, C, D, E, F, G, H;
  logic [7:0]  V;
  logic [2:0]  PTR;
  logic        FULL, DONE, ERR;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_slot [8];
  logic [7:0]  m_v;
  logic [2:0]  m_ptr;
  logic        m_err, m_full, m_done;
  logic [15:0] exp_q [$];
  logic [2:0]  slot_q [$];

  demux16b8_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .I(I), .S(S), .WE(WE), .AUTO(AUTO), .CLR(CLR),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .V(V), .PTR(PTR), .FULL(FULL), .DONE(DONE), .ERR(ERR), .dbg_state(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] dut_slot(input int k);
    case (k)
      0: return A;
      1: return B;
      2: return C;
      3: return D;
      4: return E;
      5: return F;
      6: return G;
      default: return H;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_slot[k] = '0;
    m_v = '0; m_ptr = '0; m_err = 0; m_full = 0; m_done = 0;
    exp_q.delete(); slot_q.delete();
  endtask

  task automatic do_reset();
    RST_N = 0; WE = 0; CLR = 0; AUTO = 0; S = '0; I = '0;
    repeat (2) @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RST_N = 1;
  endtask

  // Drive one cycle, advance the model across the edge, sample 1ns after the edge.
  task automatic step(input logic we, input logic auto, input logic [2:0] s,
                      input logic [15:0] i, input logic clr);
    int t;
    @(negedge CLK);
    WE = we; AUTO = auto; S = s; I = i; CLR = clr;
    @(posedge CLK);
    m_done = 0;
    if (clr) begin
      m_v = '0; m_ptr = '0; m_err = 0; m_full = 0;
    end else if (we) begin
      t = auto ? int'(m_ptr) : int'(s);
      if (m_v[t]) m_err = 1;
      m_slot[t] = i;
      m_v[t] = 1'b1;
      if (auto) m_ptr = m_ptr + 3'd1;
      exp_q.push_back(i);
      slot_q.push_back(3'(t));
      if (m_v == 8'hFF && !m_full) begin
        m_full = 1; m_done = 1;
      end
    end
    #1;
    WE = 0; CLR = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (V !== 8'h00) begin bad++; $display("FAIL reset_v got=%h exp=00", V); end
    total++; if (PTR !== 3'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", PTR); end
    total++; if ({FULL, DONE, ERR} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {FULL, DONE, ERR}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    for (int k = 0; k < 8; k++) begin
      total++; if (dut_slot(k) !== 16'h0) begin bad++; $display("FAIL reset_slot%0d got=%h exp=0000", k, dut_slot(k)); end
    end
  endtask

  task automatic test_auto_fill();
    logic [15:0] e; logic [2:0] t;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 3'd0, 16'(k), 0);
      e = exp_q.pop_front(); t = slot_q.pop_front();
      total++; if (dut_slot(int'(t)) !== e) begin bad++; $display("FAIL auto_slot%0d got=%h exp=%h", t, dut_slot(int'(t)), e); end
      total++; if (V !== 8'((16'h1 << (k + 1)) - 1)) begin bad++; $display("FAIL auto_v k=%0d got=%h", k, V); end
      total++; if (DONE !== (k == 7)) begin bad++; $display("FAIL auto_done k=%0d got=%b", k, DONE); end
      total++; if (PTR !== 3'(k + 1)) begin bad++; $display("FAIL auto_ptr k=%0d got=%0d", k, PTR); end
    end
    total++; if (FULL !== 1'b1 || ERR !== 1'b0) begin bad++; $display("FAIL auto_full_err got=%b%b exp=10", FULL, ERR); end
    step(0, 0, 3'd0, 16'h0, 0);
    total++; if (DONE !== 1'b0 || FULL !== 1'b1) begin bad++; $display("FAIL auto_done_once got=%b full=%b", DONE, FULL); end
  endtask

  task automatic test_explicit();
    do_reset();
    step(1, 0, 3'd5, 16'hBEEF, 0);
    void'(exp_q.pop_front()); void'(slot_q.pop_front());
    total++; if (F !== 16'hBEEF) begin bad++; $display("FAIL expl_f got=%h exp=beef", F); end
    total++; if (V !== 8'h20 || PTR !== 3'd0) begin bad++; $display("FAIL expl_v_ptr got=%h/%0d exp=20/0", V, PTR); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL expl_err0 got=%b exp=0", ERR); end
    step(1, 0, 3'd5, 16'h1234, 0);
    void'(exp_q.pop_front()); void'(slot_q.pop_front());
    total++; if (F !== 16'h1234 || ERR !== 1'b1) begin bad++; $display("FAIL expl_ovw got=%h/%b exp=1234/1", F, ERR); end
    repeat (3) step(0, 0, 3'd2, 16'h0, 0);
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL expl_err_sticky got=%b exp=1", ERR); end
  endtask

  task automatic test_clr_priority();
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 1, 3'd0, 16'h0010 + 16'(k), 0);
    step(1, 0, 3'd3, 16'h7777, 0);
    exp_q.delete(); slot_q.delete();
    total++; if (ERR !== 1'b1 || FULL !== 1'b1) begin bad++; $display("FAIL clr_pre got=%b%b exp=11", ERR, FULL); end
    step(1, 1, 3'd0, 16'hFFFF, 1);
    total++; if (V !== 8'h00 || PTR !== 3'd0) begin bad++; $display("FAIL clr_v_ptr got=%h/%0d exp=00/0", V, PTR); end
    total++; if ({ERR, FULL, DONE} !== 3'b000) begin bad++; $display("FAIL clr_flags got=%b exp=000", {ERR, FULL, DONE}); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (dut_slot(k) !== m_slot[k] || dut_slot(k) === 16'hFFFF) begin
        bad++; $display("FAIL clr_keep_slot%0d got=%h exp=%h", k, dut_slot(k), m_slot[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e; logic [2:0] t;
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1, 3'd0, 16'h00A0 + 16'(k), 0);
    exp_q.delete(); slot_q.delete();
    @(negedge CLK);
    #2 RST_N = 0;
    #1;
    total++; if (V !== 8'h00 || PTR !== 3'd0 || FULL !== 1'b0) begin bad++; $display("FAIL arst_state got=%h/%0d/%b exp=00/0/0", V, PTR, FULL); end
    total++; if ({A, B, C} !== 48'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", {A, B, C}); end
    model_reset();
    #1 RST_N = 1;
    step(1, 1, 3'd6, 16'h0055, 0);
    e = exp_q.pop_front(); t = slot_q.pop_front();
    total++; if (A !== 16'h0055 || t !== 3'd0 || dut_slot(int'(t)) !== e) begin bad++; $display("FAIL arst_first_write got=%h exp=0055", A); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1, 3'd0, 16'h0300 + 16'(k), 0);
    exp_q.delete(); slot_q.delete();
    for (int c = 0; c < 10; c++) begin
      step(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 0);
      total++; if (V !== 8'h07 || PTR !== 3'd3 || DONE !== 1'b0) begin bad++; $display("FAIL idle_state c=%0d got=%h/%0d/%b", c, V, PTR, DONE); end
      for (int k = 0; k < 8; k++) begin
        total++; if (dut_slot(k) !== m_slot[k]) begin bad++; $display("FAIL idle_slot%0d got=%h exp=%h", k, dut_slot(k), m_slot[k]); end
      end
    end
  endtask

  task automatic test_explicit_fill();
    do_reset();
    for (int s = 7; s >= 0; s--) begin
      step(1, 0, 3'(s), 16'h00C0 + 16'(s), 0);
      total++; if (DONE !== (s == 0)) begin bad++; $display("FAIL efill_done s=%0d got=%b", s, DONE); end
    end
    exp_q.delete(); slot_q.delete();
    total++; if (FULL !== 1'b1 || ERR !== 1'b0 || PTR !== 3'd0) begin bad++; $display("FAIL efill_full got=%b/%b/%0d exp=1/0/0", FULL, ERR, PTR); end
    step(1, 0, 3'd0, 16'h00DD, 0);
    void'(exp_q.pop_front()); void'(slot_q.pop_front());
    total++; if (DONE !== 1'b0 || FULL !== 1'b1 || ERR !== 1'b1 || A !== 16'h00DD) begin
      bad++; $display("FAIL efill_ovw got done=%b full=%b err=%b a=%h exp 0/1/1/00dd", DONE, FULL, ERR, A);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e; logic [2:0] t;
    do_reset();
    for (int c = 0; c < 150; c++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 1'($urandom_range(0, 19) == 0));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); t = slot_q.pop_front();
        total++; if (dut_slot(int'(t)) !== e) begin bad++; $display("FAIL b2b_slot%0d c=%0d got=%h exp=%h", t, c, dut_slot(int'(t)), e); end
      end
      total++;
      if (V !== m_v || PTR !== m_ptr || ERR !== m_err || FULL !== m_full || DONE !== m_done) begin
        bad++;
        $display("FAIL b2b_state c=%0d got v=%h p=%0d e=%b f=%b d=%b exp v=%h p=%0d e=%b f=%b d=%b",
                 c, V, PTR, ERR, FULL, DONE, m_v, m_ptr, m_err, m_full, m_done);
      end
    end
  endtask

  initial begin
    RST_N = 0; WE = 0; CLR = 0; AUTO = 0; S = '0; I = '0;
    model_reset();
    test_reset();
    test_auto_fill();
    test_explicit();
    test_clr_priority();
    test_async_reset();
    test_idle();
    test_explicit_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
